// File: rtl/sm_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : sm_accumulator_if
// Brief    : Term-in / result-out handshake bundle for the sign-magnitude
//            streaming accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface sm_accumulator_if #(
    parameter int N     = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport master (
        output in_valid, in_data, in_last, clear, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, clear, out_ready,
        output in_ready, out_valid, out_data, out_count, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/sm_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sm_accumulator
// Brief    : Sums a frame of sign-magnitude terms with saturation and holds
//            the result on a valid/ready port until consumed.
// Revision : 1.0 - initial release
// ============================================================================
module sm_accumulator #(
    parameter int N     = 32,
    parameter int Q     = 16,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sm_accumulator_if.slave      bus
);

    if (Q > N - 1) begin : g_q_range_check
        $error("sm_accumulator: Q must not exceed the magnitude width N-1");
    end

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_EMIT  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [N-1:0]     acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             sat_q,   sat_d;

    logic             accept;
    logic             consume;

    logic [N-2:0]     ma, mb, res_mag;
    logic [N-1:0]     mag_sum;
    logic             sa, sb, res_sign;
    logic [N-1:0]     add_res;
    logic             add_ovf;

    // clear drops any term offered in the same cycle
    assign accept  = bus.in_valid & (state_q == ST_ACCUM) & ~bus.clear;
    assign consume = bus.out_ready & (state_q == ST_EMIT) & ~bus.clear;

    // Sign-magnitude add; a -0 operand is folded to +0 before the sign test.
    always_comb begin
        ma       = acc_q[N-2:0];
        mb       = bus.in_data[N-2:0];
        sa       = acc_q[N-1] & (|ma);
        sb       = bus.in_data[N-1] & (|mb);
        mag_sum  = {1'b0, ma} + {1'b0, mb};
        add_ovf  = 1'b0;
        res_sign = 1'b0;
        res_mag  = '0;
        if (sa == sb) begin
            res_sign = sa;
            if (mag_sum[N-1]) begin
                res_mag = '1;
                add_ovf = 1'b1;
            end else begin
                res_mag = mag_sum[N-2:0];
            end
        end else if (ma >= mb) begin
            res_sign = sa;
            res_mag  = ma - mb;
        end else begin
            res_sign = sb;
            res_mag  = mb - ma;
        end
        add_res = {res_sign & (|res_mag), res_mag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (bus.clear) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        acc_d = add_res;
                        cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                        sat_d = sat_q | add_ovf;
                        if (bus.in_last) begin
                            state_d = ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (consume) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_ACCUM);
        bus.out_valid = (state_q == ST_EMIT);
        bus.out_data  = acc_q;
        bus.out_count = cnt_q;
        bus.out_sat   = sat_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_accumulator
// Brief    : Randomized and directed checks of sm_accumulator against an
//            integer-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_accumulator;

    localparam int N    = 16;
    localparam int MAXV = 32767;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sm_accumulator_if #(.N(N), .CNT_W(8)) bus  ();
    sm_accumulator_if #(.N(N), .CNT_W(2)) bus2 ();

    sm_accumulator #(.N(N), .Q(8), .CNT_W(8)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    sm_accumulator #(.N(N), .Q(8), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: the frame sum as a plain integer
    int m_acc;
    int m_cnt;
    int m_sat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sm2int(input logic [15:0] v);
        int m;
        m = int'(v[14:0]);
        return v[15] ? -m : m;
    endfunction

    function automatic logic [15:0] int2sm(input int x);
        logic [15:0] r;
        if (x < 0) begin
            r     = 16'(-x);
            r[15] = 1'b1;
        end else begin
            r = 16'(x);
        end
        return r;
    endfunction

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_sat = 0;
    endtask

    task automatic model_add(input logic [15:0] t);
        int s;
        s = m_acc + sm2int(t);
        if (s > MAXV) begin
            s = MAXV;
            m_sat = 1;
        end else if (s < -MAXV) begin
            s = -MAXV;
            m_sat = 1;
        end
        m_acc = s;
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic push(input logic [15:0] d, input logic last);
        @(negedge clk);
        chk("in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        model_add(d);
    endtask

    task automatic check_result();
        chk("out_valid", bus.out_valid, 1);
        chk("out_data",  bus.out_data,  int2sm(m_acc));
        chk("out_count", bus.out_count, m_cnt);
        chk("out_sat",   bus.out_sat,   m_sat);
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("post_hs_valid", bus.out_valid, 0);
        chk("post_hs_ready", bus.in_ready, 1);
        model_clear();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] t;
        int          len;
        int          hold;

        rst = 1'b1;
        bus.in_valid  = 0; bus.in_data  = '0; bus.in_last  = 0; bus.clear  = 0; bus.out_ready  = 0;
        bus2.in_valid = 0; bus2.in_data = '0; bus2.in_last = 0; bus2.clear = 0; bus2.out_ready = 0;
        model_clear();

        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_out_count", bus.out_count, 0);
        chk("rst_out_sat",   bus.out_sat,   0);
        chk("rst_in_ready",  bus.in_ready,  1);
        rst = 1'b0;

        // Mixed-sign frame
        push(16'h0180, 0); push(16'h8080, 0); push(16'h0200, 1);
        check_result();
        chk("t1_value", bus.out_data, 16'h0300);
        consume();

        // Cancellation never yields -0; single negative term
        push(16'h0100, 0); push(16'h8100, 1);
        chk("t2_zero", bus.out_data, 16'h0000);
        check_result();
        consume();
        push(16'h8080, 1);
        chk("t2_single", bus.out_data, 16'h8080);
        check_result();
        consume();

        // Saturation then continued accumulation from the clamped value
        push(16'h7F00, 0); push(16'h7F00, 0);
        chk("t3_clamp", bus.out_data, 16'h7FFF);
        push(16'h8100, 1);
        chk("t3_final", bus.out_data, 16'h7EFF);
        check_result();
        consume();

        // Backpressure: result held, offered terms ignored
        push(16'h0010, 0); push(16'h0020, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_in_ready", bus.in_ready, 0);
            check_result();
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        consume();
        push(16'h0005, 1);
        check_result();
        consume();

        // Clear mid-frame drops accumulated and concurrently offered terms
        push(16'h0300, 0); push(16'h0400, 0);
        @(negedge clk);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0700;
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
        chk("t5_clr_valid", bus.out_valid, 0);
        chk("t5_clr_count", bus.out_count, 0);
        push(16'h0002, 1);
        check_result();
        // Clear while a result is pending
        @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        model_clear();
        chk("t5_emit_clr_valid", bus.out_valid, 0);
        chk("t5_emit_clr_ready", bus.in_ready, 1);
        chk("t5_emit_clr_data",  bus.out_data, 0);

        // Asynchronous reset mid-frame
        push(16'h1234, 0); push(16'h0111, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_arst_data",  bus.out_data,  0);
        chk("t5_arst_count", bus.out_count, 0);
        chk("t5_arst_valid", bus.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();

        // Randomized frames with random result backpressure
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 1) == 1)
                    t = 16'($urandom);
                else
                    t = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 511))};
                push(t, (k == len - 1));
            end
            check_result();
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("rnd_hold_valid", bus.out_valid, 1);
            end
            consume();
        end

        // Narrow counter saturates while the sum keeps growing
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1;
            bus2.in_data  = 16'h0001;
            bus2.in_last  = (i == 4);
            @(posedge clk);
            #1;
            bus2.in_valid = 1'b0;
            bus2.in_last  = 1'b0;
        end
        chk("t6_valid", bus2.out_valid, 1);
        chk("t6_data",  bus2.out_data,  16'h0005);
        chk("t6_count", bus2.out_count, 3);
        chk("t6_sat",   bus2.out_sat,   0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
